// File: rtl/uart_param_txrx.sv
// uart_param_txrx: full-duplex UART with configurable frame format and an RX FIFO carrying per-word error flags.
module uart_param_txrx #(
  parameter int CLK_HZ     = 80000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_TX_Valid,
  input  logic [DATA_BITS-1:0]          i_TX_Data,
  output logic                          o_TX_Ready,
  output logic                          o_TX,
  input  logic                          i_RX,
  input  logic                          i_RX_Read,
  output logic                          o_RX_Valid,
  output logic [DATA_BITS-1:0]          o_RX_Data,
  output logic                          o_RX_Parity_Err,
  output logic                          o_RX_Frame_Err,
  output logic [$clog2(FIFO_DEPTH):0]   o_RX_Count,
  input  logic                          i_Clear_Ovr,
  output logic                          o_RX_Overrun
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int CW   = $clog2(STOP_BITS * DIV + 1);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam int EW   = DATA_BITS + 2;
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

  tx_state_t              tx_state_q, tx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]          tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_bit_done, tx_accept;

  rx_state_t              rx_state_q, rx_state_d;
  logic [1:0]             rx_sync_q, rx_sync_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]          rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_line, rx_bit_done, rx_wr;
  logic [EW-1:0]          rx_entry;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          count_q, count_d;
  logic                   ovr_q, ovr_d;
  logic                   full, rd, push;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      rx_state_q <= R_IDLE;
      rx_sync_q  <= 2'b11;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      rx_state_q <= rx_state_d;
      rx_sync_q  <= rx_sync_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_bit_done = tx_cnt_q == BIT_END;
  assign tx_accept   = i_TX_Valid && o_TX_Ready;

  // An accept in the last stop cycle overrides the return to idle, giving back-to-back frames.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      T_IDLE: tx_cnt_d = '0;
      T_START: if (tx_bit_done) begin
        tx_state_d = T_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
      T_DATA: if (tx_bit_done) begin
        tx_cnt_d   = '0;
        tx_bit_d   = tx_bit_q + 1'b1;
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_BIT) tx_state_d = (PARITY != 0) ? T_PARITY : T_STOP;
      end
      T_PARITY: if (tx_bit_done) begin
        tx_state_d = T_STOP;
        tx_cnt_d   = '0;
      end
      T_STOP: if (tx_cnt_q == STOP_END) begin
        tx_state_d = T_IDLE;
        tx_cnt_d   = '0;
      end
      default: tx_state_d = T_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_d = T_START;
      tx_cnt_d   = '0;
      tx_shift_d = i_TX_Data;
      tx_par_d   = (PARITY == 1) ? ~^i_TX_Data : ^i_TX_Data;
    end
  end

  always_comb begin
    o_TX       = (tx_state_q == T_START)  ? 1'b0 :
                 (tx_state_q == T_DATA)   ? tx_shift_q[0] :
                 (tx_state_q == T_PARITY) ? tx_par_q : 1'b1;
    o_TX_Ready = (tx_state_q == T_IDLE) || (tx_state_q == T_STOP && tx_cnt_q == STOP_END);
  end

  assign rx_sync_d   = {rx_sync_q[0], i_RX};
  assign rx_line     = rx_sync_q[1];
  assign rx_bit_done = rx_cnt_q == BIT_END;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d  = '0;
        rx_perr_d = 1'b0;
        if (!rx_line) rx_state_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF_END) begin
        rx_state_d = rx_line ? R_IDLE : R_DATA;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
      R_DATA: if (rx_bit_done) begin
        rx_cnt_d   = '0;
        rx_bit_d   = rx_bit_q + 1'b1;
        rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? R_PARITY : R_STOP;
      end
      R_PARITY: if (rx_bit_done) begin
        rx_state_d = R_STOP;
        rx_cnt_d   = '0;
        rx_perr_d  = (PARITY == 1) ? ~^{rx_shift_q, rx_line} : ^{rx_shift_q, rx_line};
      end
      R_STOP: if (rx_bit_done) begin
        rx_state_d = rx_line ? R_IDLE : R_WAIT;
        rx_cnt_d   = '0;
      end
      R_WAIT: begin
        rx_cnt_d = '0;
        if (rx_line) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_wr    = (rx_state_q == R_STOP) && rx_bit_done;
    rx_entry = {~rx_line, rx_perr_q, rx_shift_q};
  end

  // A full FIFO still accepts a write when the same cycle pops the head.
  always_comb begin
    full     = count_q == NW'(FIFO_DEPTH);
    rd       = i_RX_Read && (count_q != '0);
    push     = rx_wr && (!full || rd);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = rx_entry;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + NW'(push) - NW'(rd);
    ovr_d    = (rx_wr && full && !rd) ? 1'b1 : i_Clear_Ovr ? 1'b0 : ovr_q;
  end

  assign o_RX_Valid = count_q != '0;
  assign {o_RX_Frame_Err, o_RX_Parity_Err, o_RX_Data} = mem_q[rd_ptr_q];
  assign o_RX_Count   = count_q;
  assign o_RX_Overrun = ovr_q;
endmodule

// File: doc/uart_param_txrx.md
Name: uart_param_txrx

Overview:
- Parametrised successor UART: full-duplex TX/RX with configurable frame format (data bits, parity, stop bits).
- TX side uses a valid/ready handshake. RX side uses a first-word-fall-through FIFO with per-word error flags and a sticky overrun flag.
- Single clock domain; sits between the board UART pins and the LED/command logic.

Parameters:
- CLK_HZ, 80000000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD (integer truncation); every bit lasts exactly DIV clocks.
- DATA_BITS, 8, data bits per frame, legal 5..8.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits transmitted, legal 1 or 2.
- FIFO_DEPTH, 16, RX FIFO entries, power of two, >=2.

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_TX_Valid  in  1  TX word offered.
- i_TX_Data  in  DATA_BITS  TX word; sampled only on accept.
- o_TX_Ready  out  1  TX can accept a word.
- o_TX  out  1  serial line out, idle high.
- i_RX  in  1  serial line in; asynchronous to i_Clock.
- i_RX_Read  in  1  pop FIFO head.
- o_RX_Valid  out  1  FIFO not empty.
- o_RX_Data  out  DATA_BITS  FIFO head data.
- o_RX_Parity_Err  out  1  FIFO head was received with a parity error.
- o_RX_Frame_Err  out  1  FIFO head was received with stop bit low.
- o_RX_Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- i_Clear_Ovr  in  1  clears o_RX_Overrun.
- o_RX_Overrun  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset values: o_TX=1, o_TX_Ready=1, o_RX_Valid=0, o_RX_Count=0, o_RX_Overrun=0, o_RX_Data=0, both error flags 0. Both state machines return to IDLE and both FIFO pointers return to 0.
- Reset mid-frame: the frame in progress is aborted and o_TX goes high on the next cycle.
- TX states: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
  - Accept occurs when i_TX_Valid && o_TX_Ready. o_TX_Ready drops the following cycle, in the same cycle that o_TX goes low for the start bit.
  - Data is sent LSB first. Odd parity makes the count of 1s in data plus parity odd; even parity makes it even.
  - STOP holds the line high for STOP_BITS*DIV cycles. o_TX_Ready rises in the last cycle of STOP.
  - If i_TX_Valid is high in that last STOP cycle, the next start bit follows with no idle gap.
  - o_TX_Ready is low throughout a frame; i_TX_Valid is ignored while it is low.
- RX synchroniser: i_RX passes through 2 flops before use; all references to "line" below mean the synchronised value.
- RX states: IDLE -> START -> DATA -> PARITY (only if enabled) -> STOP -> (WAIT_HIGH) -> IDLE.
  - IDLE: a low line moves to START.
  - START: counts DIV/2 cycles, then resamples. A high line is a false start: return to IDLE, nothing written.
  - DATA / PARITY / STOP: each bit is sampled DIV cycles after the previous sample. Only the first stop bit is checked.
  - At the stop-bit sample, the entry {frame_err, parity_err, data} is written to the FIFO.
  - If the stop bit was low, go to WAIT_HIGH. Remain there until the line is high, so a break produces exactly one entry.
- RX FIFO:
  - First-word fall-through: o_RX_Data and both error flags show the head combinationally from the registered pointers. o_RX_Valid = (count != 0).
  - i_RX_Read with o_RX_Valid=1 pops the head; the new head is visible the next cycle. i_RX_Read while empty is ignored.
  - Write while full with no read in the same cycle: the word is dropped, o_RX_Overrun is set, and the FIFO contents are unchanged.
  - Write and read in the same cycle while full: both succeed, count stays FIFO_DEPTH, no overrun.
  - Write and read in the same cycle while empty: count goes 0->1 and the read is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Overrun flag: set has priority over i_Clear_Ovr when both occur in the same cycle.

Test Plan:
- CLK_HZ=8000000, BAUD=1000000 (DIV=8), 8N1: TX 0xA5 -> o_TX low 8 cycles starting the cycle after accept, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, high 8 cycles; o_TX_Ready low for 79 cycles.
- RX loopback of 0x3C, 0xFF, 0x00 at 8E2 -> FIFO holds 3 entries in order, no error flags; three reads return 0x3C, 0xFF, 0x00, then o_RX_Valid=0.
- 8O1 RX frame 0x01 with parity bit 1 -> entry data 0x01 with o_RX_Parity_Err=1; frame 0x03 with parity bit 1 -> no error.
- RX glitch: line low for 3 cycles -> no FIFO write. RX held low for 40 bit-times -> exactly one entry, data 0x00, frame error, no further entries until the line returns high.
- FIFO_DEPTH=4: receive 5 frames with no reads -> count=4, o_RX_Overrun=1, head is the first word. Pulse i_Clear_Ovr -> flag 0. A 6th frame arriving while i_RX_Read is pulsed on the write cycle -> count stays 4, no overrun.
- Assert i_Reset mid-TX (bit 3) and mid-RX -> o_TX=1 next cycle, o_TX_Ready=1, count=0; a fresh frame then transmits and receives correctly.
